// File: rtl/rggen_indirect_access_initiator.sv
// Indirect register access initiator.
// Turns one command (read/write to an index) into register-bus traffic:
// an optional write of the index to INDEX_ADDRESS, then one access to
// DATA_ADDRESS, then a response. The last successfully written index is
// cached so that repeated accesses to the same index skip the index write.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The command side is ready only in IDLE. The register
// bus request holds all fields stable while valid is high and ready is low,
// and drops valid for at least one cycle after each completed transfer. The
// response stays valid with stable status/data until i_response_ready.
module rggen_indirect_access_initiator #(
  parameter int                         ADDRESS_WIDTH  = 8,
  parameter int                         BUS_WIDTH      = 32,
  parameter int                         INDEX_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0]   INDEX_ADDRESS  = {ADDRESS_WIDTH{1'b0}},
  parameter logic [ADDRESS_WIDTH-1:0]   DATA_ADDRESS   = ADDRESS_WIDTH'(4),
  parameter int                         TIMEOUT_CYCLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_command_valid,
  output logic                     o_command_ready,
  input  logic                     i_command_write,
  input  logic [INDEX_WIDTH-1:0]   i_command_index,
  input  logic [BUS_WIDTH-1:0]     i_command_data,
  input  logic [BUS_WIDTH/8-1:0]   i_command_strobe,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output logic [1:0]               o_response_status,
  output logic [BUS_WIDTH-1:0]     o_response_data,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam int STRB_W = BUS_WIDTH / 8;
  // Counter only has to reach TIMEOUT_CYCLES-1; the timeout fires on that cycle.
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_INDEX    = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_RESPONSE = 2'd3;

  logic [1:0]             state_q,        state_d;
  logic                   reg_valid_q,    reg_valid_d;
  logic [CNT_W-1:0]       wait_cnt_q,     wait_cnt_d;
  logic                   cmd_write_q,    cmd_write_d;
  logic [INDEX_WIDTH-1:0] cmd_index_q,    cmd_index_d;
  logic [BUS_WIDTH-1:0]   cmd_data_q,     cmd_data_d;
  logic [STRB_W-1:0]      cmd_strobe_q,   cmd_strobe_d;
  logic                   cache_valid_q,  cache_valid_d;
  logic [INDEX_WIDTH-1:0] cache_index_q,  cache_index_d;
  logic [1:0]             resp_status_q,  resp_status_d;
  logic [BUS_WIDTH-1:0]   resp_data_q,    resp_data_d;

  logic phase_done;
  logic timed_out;

  assign phase_done = reg_valid_q && i_register_ready;
  assign timed_out  = (TIMEOUT_CYCLES > 0) && reg_valid_q && !i_register_ready &&
                      (wait_cnt_q == CNT_LAST);

  // Next-state logic: command capture, bus phase sequencing, timeout, response.
  always_comb begin
    state_d       = state_q;
    reg_valid_d   = reg_valid_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_write_d   = cmd_write_q;
    cmd_index_d   = cmd_index_q;
    cmd_data_d    = cmd_data_q;
    cmd_strobe_d  = cmd_strobe_q;
    cache_valid_d = cache_valid_q;
    cache_index_d = cache_index_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_command_valid) begin
          cmd_write_d  = i_command_write;
          cmd_index_d  = i_command_index;
          cmd_data_d   = i_command_data;
          cmd_strobe_d = i_command_strobe;
          reg_valid_d  = 1'b1;
          wait_cnt_d   = '0;
          state_d      = (cache_valid_q && (cache_index_q == i_command_index)) ?
                         ST_DATA : ST_INDEX;
        end
      end
      ST_INDEX: begin
        if (phase_done) begin
          // Ready takes priority over a timeout landing on the same cycle.
          reg_valid_d = 1'b0;
          wait_cnt_d  = '0;
          if (i_register_status[1]) begin
            resp_status_d = i_register_status;
            resp_data_d   = '0;
            cache_valid_d = 1'b0;
            state_d       = ST_RESPONSE;
          end else begin
            cache_index_d = cmd_index_q;
            cache_valid_d = 1'b1;
            state_d       = ST_DATA;
          end
        end else if (timed_out) begin
          reg_valid_d   = 1'b0;
          resp_status_d = 2'b10;
          resp_data_d   = '0;
          cache_valid_d = 1'b0;
          state_d       = ST_RESPONSE;
        end else if (reg_valid_q) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (phase_done) begin
          reg_valid_d   = 1'b0;
          resp_status_d = i_register_status;
          resp_data_d   = cmd_write_q ? '0 : i_register_read_data;
          state_d       = ST_RESPONSE;
        end else if (timed_out) begin
          reg_valid_d   = 1'b0;
          resp_status_d = 2'b10;
          resp_data_d   = '0;
          cache_valid_d = 1'b0;
          state_d       = ST_RESPONSE;
        end else if (reg_valid_q) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          // One idle bus cycle after the index write, then issue the data access.
          reg_valid_d = 1'b1;
        end
      end
      default: begin
        if (i_response_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      reg_valid_q   <= 1'b0;
      wait_cnt_q    <= '0;
      cmd_write_q   <= 1'b0;
      cmd_index_q   <= '0;
      cmd_data_q    <= '0;
      cmd_strobe_q  <= '0;
      cache_valid_q <= 1'b0;
      cache_index_q <= '0;
      resp_status_q <= 2'b00;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      reg_valid_q   <= reg_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_write_q   <= cmd_write_d;
      cmd_index_q   <= cmd_index_d;
      cmd_data_q    <= cmd_data_d;
      cmd_strobe_q  <= cmd_strobe_d;
      cache_valid_q <= cache_valid_d;
      cache_index_q <= cache_index_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
    end
  end

  // Register bus request fields; all zero whenever no request is outstanding.
  always_comb begin
    o_register_access     = 2'b00;
    o_register_address    = '0;
    o_register_write_data = '0;
    o_register_strobe     = '0;
    if (reg_valid_q) begin
      if (state_q == ST_INDEX) begin
        o_register_access     = 2'b11;
        o_register_address    = INDEX_ADDRESS;
        o_register_write_data = BUS_WIDTH'(cmd_index_q);
        o_register_strobe     = '1;
      end else if (state_q == ST_DATA) begin
        o_register_access     = cmd_write_q ? 2'b11 : 2'b10;
        o_register_address    = DATA_ADDRESS;
        o_register_write_data = cmd_write_q ? cmd_data_q : '0;
        o_register_strobe     = cmd_write_q ? cmd_strobe_q : '0;
      end
    end
  end

  assign o_register_valid  = reg_valid_q;
  assign o_command_ready   = (state_q == ST_IDLE);
  assign o_response_valid  = (state_q == ST_RESPONSE);
  assign o_response_status = resp_status_q;
  assign o_response_data   = resp_data_q;

endmodule
